dmem_arbiter: RTL and testbench

Arbitrates the CPU data-memory port between two requesters: the MEM-stage access (dce/daddr/we/dre/din) and an auxiliary master (debug/loader/DMA).
Sequences each access over a req/ack bus to a variable-latency data memory.
Stalls the pipeline while a MEM-stage access is outstanding.
Sits between the MEM stage and the data RAM/bridge.

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: round-robin between the MEM-stage access (m0) and an
// auxiliary master (m1), sequencing each access over a req/ack bus with a timeout abort.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              m0_dce,
    input  logic [ADDR_W-1:0] m0_daddr,
    input  logic [3:0]        m0_we,
    input  logic [3:0]        m0_dre,
    input  logic [DATA_W-1:0] m0_din,
    output logic [DATA_W-1:0] m0_dout,
    output logic              m0_stall,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_we,
    input  logic [3:0]        m1_re,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_we,
    output logic [3:0]        bus_re,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BUS0  = 3'd1,
        BUS1  = 3'd2,
        RESP0 = 3'd3,
        RESP1 = 3'd4
    } state_t;

    // Abort fires on the cycle the counter would reach TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_rr_last;
    logic [7:0]        r_cnt;
    logic              r_bus_req;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_we;
    logic [3:0]        r_re;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_m0_dout;
    logic [DATA_W-1:0] r_m1_rdata;
    logic              r_m1_done;
    logic              r_bus_err;

    logic              w_grant_m1;
    logic              w_timeout;

    // r_rr_last=1 means m1 was granted last, so m0 wins the next contention.
    assign w_grant_m1 = m1_req & (~m0_dce | ~r_rr_last);
    assign w_timeout  = (r_cnt == TO_LAST);

    // Arbitration / bus sequencing FSM with registered bus and response outputs.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state    <= IDLE;
            r_rr_last  <= 1'b1;
            r_cnt      <= 8'd0;
            r_bus_req  <= 1'b0;
            r_addr     <= '0;
            r_we       <= 4'd0;
            r_re       <= 4'd0;
            r_wdata    <= '0;
            r_m0_dout  <= '0;
            r_m1_rdata <= '0;
            r_m1_done  <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_m1_done <= 1'b0;
            r_bus_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (m0_dce || m1_req) begin
                        r_bus_req <= 1'b1;
                        r_cnt     <= 8'd0;
                        if (m0_dce && m1_req) begin
                            r_rr_last <= w_grant_m1;
                        end else begin
                            r_rr_last <= r_rr_last;
                        end
                        if (w_grant_m1) begin
                            r_addr  <= m1_addr;
                            r_we    <= m1_we;
                            r_re    <= m1_re;
                            r_wdata <= m1_wdata;
                            r_state <= BUS1;
                        end else begin
                            r_addr  <= m0_daddr;
                            r_we    <= m0_we;
                            r_re    <= m0_dre;
                            r_wdata <= m0_din;
                            r_state <= BUS0;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUS0, BUS1: begin
                    if (bus_ack || w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_cnt     <= 8'd0;
                        r_bus_err <= ~bus_ack;
                        if (r_state == BUS0) begin
                            r_m0_dout <= bus_ack ? bus_rdata : '0;
                            r_state   <= RESP0;
                        end else begin
                            r_m1_rdata <= bus_ack ? bus_rdata : '0;
                            r_m1_done  <= 1'b1;
                            r_state    <= RESP1;
                        end
                    end else if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                RESP0:   r_state <= IDLE;
                RESP1:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m0_stall  = m0_dce & (r_state != RESP0);
    assign m0_dout   = r_m0_dout;
    assign m1_rdata  = r_m1_rdata;
    assign m1_done   = r_m1_done;
    assign bus_req   = r_bus_req;
    assign bus_addr  = r_addr;
    assign bus_we    = r_we;
    assign bus_re    = r_re;
    assign bus_wdata = r_wdata;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: scoreboard of expected completions checked by a
// negedge monitor, plus cycle-level bus/stall checks in the stimulus sequence.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_dce;
    logic [31:0] m0_daddr;
    logic [3:0]  m0_we;
    logic [3:0]  m0_dre;
    logic [31:0] m0_din;
    logic [31:0] m0_dout;
    logic        m0_stall;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic [3:0]  m1_we;
    logic [3:0]  m1_re;
    logic [31:0] m1_wdata;
    logic [31:0] m1_rdata;
    logic        m1_done;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [3:0]  bus_we;
    logic [3:0]  bus_re;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int          ack_wait;
    logic [31:0] rd_xor;
    int          slv_cnt = 0;

    typedef struct {
        bit          port;
        logic [31:0] data;
        bit          err;
    } exp_t;
    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .cpu_clk_50M(clk),      .cpu_rst_n(rst_n),
        .m0_dce(m0_dce),        .m0_daddr(m0_daddr),   .m0_we(m0_we),
        .m0_dre(m0_dre),        .m0_din(m0_din),       .m0_dout(m0_dout),
        .m0_stall(m0_stall),
        .m1_req(m1_req),        .m1_addr(m1_addr),     .m1_we(m1_we),
        .m1_re(m1_re),          .m1_wdata(m1_wdata),   .m1_rdata(m1_rdata),
        .m1_done(m1_done),
        .bus_req(bus_req),      .bus_addr(bus_addr),   .bus_we(bus_we),
        .bus_re(bus_re),        .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata),  .bus_err(bus_err)
    );

    // Memory model: acks after ack_wait cycles of bus_req (never if negative).
    always @(posedge clk) slv_cnt <= bus_req ? slv_cnt + 1 : 0;
    assign bus_ack   = bus_req && (ack_wait >= 0) && (slv_cnt == ack_wait);
    assign bus_rdata = bus_addr ^ rd_xor;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: RESP0 is the only cycle with m0_dce high and no stall.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ((m0_dce && !m0_stall) || m1_done)) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("sb_port", {31'd0, m1_done}, {31'd0, e.port});
                chk("sb_rdata", m1_done ? m1_rdata : m0_dout, e.data);
                chk("sb_bus_err", {31'd0, bus_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        rst_n = 1'b0; m0_dce = 1'b0; m0_daddr = 32'd0; m0_we = 4'd0; m0_dre = 4'd0;
        m0_din = 32'd0; m1_req = 1'b0; m1_addr = 32'd0; m1_we = 4'd0; m1_re = 4'd0;
        m1_wdata = 32'd0; ack_wait = 0; rd_xor = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_we_re", {24'd0, bus_we, bus_re}, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_m0_dout", m0_dout, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_done_err", {30'd0, m1_done, bus_err}, 32'd0);
        m0_dce = 1'b1;
        #1 chk("rst_stall_comb", {31'd0, m0_stall}, 32'd1);
        m0_dce = 1'b0;
        rst_n  = 1'b1;
        tick();

        // m0 read, ack in first BUS cycle
        rd_xor = 32'hDEADBEFF; ack_wait = 0;
        m0_daddr = 32'h0000_0010; m0_dre = 4'b1111; m0_we = 4'd0; m0_dce = 1'b1;
        sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        #1;
        chk("t1_stall_c0", {31'd0, m0_stall}, 32'd1);
        chk("t1_req_c0", {31'd0, bus_req}, 32'd0);
        tick();
        chk("t1_req_c1", {31'd0, bus_req}, 32'd1);
        chk("t1_addr_c1", bus_addr, 32'h0000_0010);
        chk("t1_re_c1", {28'd0, bus_re}, 32'hF);
        chk("t1_stall_c1", {31'd0, m0_stall}, 32'd1);
        tick();
        chk("t1_req_c2", {31'd0, bus_req}, 32'd0);
        chk("t1_stall_c2", {31'd0, m0_stall}, 32'd0);
        chk("t1_dout", m0_dout, 32'hDEADBEEF);
        tick();
        m0_dce = 1'b0; m0_dre = 4'd0;

        // m0 write, 3 wait cycles, requester inputs change mid-access
        rd_xor = 32'h1234_5678; ack_wait = 3;
        m0_daddr = 32'h0000_0020; m0_we = 4'b0100; m0_din = 32'h00AB_0000; m0_dce = 1'b1;
        sb.push_back('{1'b0, 32'h1234_5658, 1'b0});
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_req", {31'd0, bus_req}, 32'd1);
            chk("t2_we", {28'd0, bus_we}, 32'h4);
            chk("t2_addr", bus_addr, 32'h0000_0020);
            chk("t2_wdata", bus_wdata, 32'h00AB_0000);
            chk("t2_stall", {31'd0, m0_stall}, 32'd1);
            if (i == 0) begin
                m0_daddr = 32'hFFFF_0000; m0_din = 32'hFFFF_FFFF; m0_we = 4'hF;
            end
            tick();
        end
        chk("t2_req_resp", {31'd0, bus_req}, 32'd0);
        chk("t2_stall_resp", {31'd0, m0_stall}, 32'd0);
        tick();
        m0_dce = 1'b0; m0_we = 4'd0;

        // timeout abort (TIMEOUT=4)
        ack_wait = -1;
        m0_daddr = 32'h0000_0030; m0_dre = 4'hF; m0_dce = 1'b1;
        sb.push_back('{1'b0, 32'd0, 1'b1});
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t4_req", {31'd0, bus_req}, 32'd1);
            chk("t4_err_low", {31'd0, bus_err}, 32'd0);
            tick();
        end
        chk("t4_req_drop", {31'd0, bus_req}, 32'd0);
        chk("t4_err_pulse", {31'd0, bus_err}, 32'd1);
        chk("t4_stall_rel", {31'd0, m0_stall}, 32'd0);
        chk("t4_dout_zero", m0_dout, 32'd0);
        tick();
        m0_dce = 1'b0;
        chk("t4_err_1cyc", {31'd0, bus_err}, 32'd0);

        // contention from reset: grants alternate m0, m1, m0, m1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ack_wait = 0; rd_xor = 32'h0F0F_0000;
        m0_daddr = 32'h0000_0100; m0_dre = 4'hF;
        m1_addr = 32'h0000_0200; m1_re = 4'h3; m1_we = 4'd0;
        m0_dce = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{k[0], (k[0] ? 32'h0000_0200 : 32'h0000_0100) ^ 32'h0F0F_0000, 1'b0});
        end
        for (int k = 0; k < 4; k++) begin
            chk("t3_idle_gap", {31'd0, bus_req}, 32'd0);
            tick();
            chk("t3_req", {31'd0, bus_req}, 32'd1);
            chk("t3_grant_addr", bus_addr, k[0] ? 32'h0000_0200 : 32'h0000_0100);
            if (k[0]) chk("t3_stall_behind_m1", {31'd0, m0_stall}, 32'd1);
            tick();
            tick();
        end
        m0_dce = 1'b0; m1_req = 1'b0;
        tick();
        chk("t3_quiet", {31'd0, bus_req}, 32'd0);

        // reset mid BUS1
        ack_wait = -1; m1_addr = 32'h0000_0300; m1_req = 1'b1;
        tick();
        chk("t5_req_bus1", {31'd0, bus_req}, 32'd1);
        #3 rst_n = 1'b0;
        #1 chk("t5_async_req", {31'd0, bus_req}, 32'd0);
        tick();
        m1_req = 1'b0;
        rst_n  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_done", {30'd0, m1_done, bus_err}, 32'd0);
            chk("t5_idle_req", {31'd0, bus_req}, 32'd0);
        end

        // m1_req dropped during BUS1, then m0 granted
        ack_wait = 2; rd_xor = 32'hA5A5_0000;
        m1_addr = 32'h0000_0400; m1_re = 4'hF; m1_req = 1'b1;
        sb.push_back('{1'b1, 32'hA5A5_0400, 1'b0});
        tick();
        m1_req = 1'b0;
        m0_daddr = 32'h0000_0500; m0_dre = 4'hF; m0_we = 4'd0; m0_dce = 1'b1;
        sb.push_back('{1'b0, 32'hA5A5_0500, 1'b0});
        #1 chk("t6_stall_wait", {31'd0, m0_stall}, 32'd1);
        tick();
        tick();
        tick();
        chk("t6_m1_done", {31'd0, m1_done}, 32'd1);
        tick();
        chk("t6_idle", {31'd0, bus_req}, 32'd0);
        tick();
        chk("t6_m0_req", {31'd0, bus_req}, 32'd1);
        chk("t6_m0_addr", bus_addr, 32'h0000_0500);
        for (int i = 0; i < 10 && m0_stall; i++) tick();
        chk("t6_m0_resp", {31'd0, m0_stall}, 32'd0);
        tick();
        m0_dce = 1'b0;

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
